// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, encodings and the E-stage control bundle
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam int REG_IDX_W = 5;
  localparam int RESULTSRC_W = 2;
  localparam int ALUCTRL_W = 3;
  typedef enum logic [RESULTSRC_W-1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;
  typedef enum logic [ALUCTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;
  typedef struct packed {
    logic                   reg_write;
    logic                   mem_write;
    logic                   jump;
    logic                   branch;
    logic                   alu_src;
    logic [RESULTSRC_W-1:0] result_src;
    logic [ALUCTRL_W-1:0]   alu_control;
  } ctrl_e_t;
  localparam ctrl_e_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_ex_pipeline_reg_if.sv
// id_ex_pipeline_reg_if: D-stage inputs, hazard controls and E-stage outputs
interface id_ex_pipeline_reg_if
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNT_W = 16
);
  logic StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [REG_IDX_W-1:0] Rs1D, Rs2D, RdD;
  logic [RESULTSRC_W-1:0] ResultSrcD;
  logic [ALUCTRL_W-1:0] ALUControlD;
  logic ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [REG_IDX_W-1:0] Rs1E, Rs2E, RdE;
  logic [RESULTSRC_W-1:0] ResultSrcE;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic [CNT_W-1:0] BubbleCnt;
  modport master (
    output StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
           RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, ResultSrcD, ALUControlD,
    input  ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
           RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ResultSrcE, ALUControlE,
           BubbleCnt
  );
  modport slave (
    input  StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
           RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, ResultSrcD, ALUControlD,
    output ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
           RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ResultSrcE, ALUControlE,
           BubbleCnt
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: enabled up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (en && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: D->E pipeline register with stall/flush and x0 masking
module id_ex_pipeline_reg #(
  parameter int XLEN = pipeline_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  id_ex_pipeline_reg_if.slave bus
);
  import pipeline_pkg::*;
  localparam logic [XLEN-1:0] ZERO = '0;
  ctrl_e_t ctrl_d, ctrl_q;
  assign ctrl_d = '{
    reg_write:   bus.RegWriteD && bus.RdD != '0,
    mem_write:   bus.MemWriteD,
    jump:        bus.JumpD,
    branch:      bus.BranchD,
    alu_src:     bus.ALUSrcD,
    result_src:  bus.ResultSrcD,
    alu_control: bus.ALUControlD
  };
  // a bubble also clears Rs/Rd so the hazard unit never forwards from it
  always_ff @(posedge clk)
    if (rst || bus.FlushE) begin
      ctrl_q       <= CTRL_BUBBLE;
      bus.ValidE   <= 1'b0;
      bus.RD1E     <= ZERO;
      bus.RD2E     <= ZERO;
      bus.ImmExtE  <= ZERO;
      bus.PCE      <= ZERO;
      bus.PCPlus4E <= ZERO;
      bus.Rs1E     <= '0;
      bus.Rs2E     <= '0;
      bus.RdE      <= '0;
    end else if (!bus.StallE) begin
      ctrl_q       <= ctrl_d;
      bus.ValidE   <= bus.ValidD;
      bus.RD1E     <= bus.Rs1D == '0 ? ZERO : bus.RD1D;
      bus.RD2E     <= bus.Rs2D == '0 ? ZERO : bus.RD2D;
      bus.ImmExtE  <= bus.ImmExtD;
      bus.PCE      <= bus.PCD;
      bus.PCPlus4E <= bus.PCPlus4D;
      bus.Rs1E     <= bus.Rs1D;
      bus.Rs2E     <= bus.Rs2D;
      bus.RdE      <= bus.RdD;
    end
  assign bus.RegWriteE   = ctrl_q.reg_write;
  assign bus.MemWriteE   = ctrl_q.mem_write;
  assign bus.JumpE       = ctrl_q.jump;
  assign bus.BranchE     = ctrl_q.branch;
  assign bus.ALUSrcE     = ctrl_q.alu_src;
  assign bus.ResultSrcE  = ctrl_q.result_src;
  assign bus.ALUControlE = ctrl_q.alu_control;
  sat_counter #(.W(CNT_W)) u_bubble (
    .clk(clk),
    .rst(rst),
    .en (bus.FlushE),
    .q  (bus.BubbleCnt)
  );
endmodule
